inst_loader: RTL and testbench



---
 rtl/proctypes_pkg.sv | 29 ++
 rtl/inst_loader_byte_assembler.sv | 41 ++++
 rtl/inst_loader.sv | 129 ++++++++++++
 tb/tb_inst_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proctypes_pkg.sv
// Shared processor types: instruction word/address shapes matching the
// instruction bank's write port, and the program loader's state encoding.
package proctypes;

  localparam int INST_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int INST_BYTES     = INST_WIDTH_DEF / 8;

  typedef logic [INST_WIDTH_DEF-1:0] instruction_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] instruction_addr_t;

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    WRITE,
    FINISH,
    CHECK,
    DONE,
    ERROR
  } loader_state_e;

  // States in which the loader pulls bytes from the receive path.
  function automatic logic takes_bytes(loader_state_e s);
    return s inside {LEN_LO, LEN_HI, PAYLOAD, CHECK};
  endfunction

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Byte-to-word assembler: shifts little-endian bytes into a word register
// and flags the byte that completes a word. The completed word is held in
// 'word' from the following cycle until the next byte is shifted in.
module byte_assembler #(
  parameter int INST_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [7:0]            byte_data,
  output logic                  word_valid,
  output logic [INST_WIDTH-1:0] word
);

  localparam int BYTES = INST_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CNT_W-1:0] byte_cnt;

  // Strobe on the byte that completes the word, so the FSM can leave
  // PAYLOAD on the same edge that consumes it.
  assign word_valid = byte_en && (byte_cnt == CNT_W'(BYTES - 1));

  // Shift new bytes in at the top so the first byte ends up in bits [7:0].
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (byte_en) begin
      word     <= {byte_data, word[INST_WIDTH-1:8]};
      byte_cnt <= word_valid ? '0 : byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Program loader: frames a UART byte stream (LEN_LO, LEN_HI, N words of
// little-endian payload) into instruction bank writes and holds the
// pipeline off until a complete program is resident.
// Optional: define INST_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over the payload.
module inst_loader
  import proctypes::*;
#(
  parameter int INST_WIDTH = INST_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk_100mhz,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [INST_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH:0]   inst_count,
  output logic                  proc_hold,
  output logic                  load_done,
  output logic                  load_error
);

  loader_state_e       state_q, state_d;
  logic [15:0]         len_q;
  logic [15:0]         len_full;
  logic [ADDR_WIDTH:0] count_inc;
  logic                accept;
  logic                arm;
  logic                asm_byte_en;
  logic                word_valid;

  assign accept      = byte_valid && byte_ready;
  assign arm         = start && (state_q inside {IDLE, DONE, ERROR});
  assign asm_byte_en = accept && (state_q == PAYLOAD);
  assign len_full    = {byte_data, len_q[7:0]};
  assign count_inc   = inst_count + 1'b1;

  byte_assembler #(.INST_WIDTH(INST_WIDTH)) u_asm (
    .clk        (clk_100mhz),
    .rst_n      (rst_n),
    .clear      (arm),
    .byte_en    (asm_byte_en),
    .byte_data  (byte_data),
    .word_valid (word_valid),
    .word       (wr_data)
  );

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR of payload bytes for the trailing checksum comparison.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n)           csum_q <= '0;
    else if (arm)         csum_q <= '0;
    else if (asm_byte_en) csum_q <= csum_q ^ byte_data;
  end
`endif

  // Next-state logic for the framing FSM.
  // NOTE: state_d is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start) state_d = LEN_LO;
      LEN_LO:            if (accept) state_d = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (32'(len_full) > (32'd1 << ADDR_WIDTH)) state_d = ERROR;
          else if (len_full == 16'd0)                state_d = FINISH;
          else                                       state_d = PAYLOAD;
        end
      end
      PAYLOAD:           if (word_valid) state_d = WRITE;
      WRITE:             state_d = (32'(count_inc) == 32'(len_q)) ? FINISH : PAYLOAD;
`ifdef INST_LOADER_CHECKSUM_EN
      FINISH:            state_d = CHECK;
      CHECK:             if (accept) state_d = (byte_data == csum_q) ? DONE : ERROR;
`else
      FINISH:            state_d = DONE;
`endif
      default:           state_d = IDLE;
    endcase
  end

  // State register plus registered outputs decoded from the next state, so
  // every output moves on the same edge as the state that implies it.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      proc_hold  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_ready <= takes_bytes(state_d);
      wr_en      <= (state_d == WRITE);
      proc_hold  <= (state_d != DONE);
      load_done  <= (state_d == DONE);
      load_error <= (state_d == ERROR);
    end
  end

  // Write pointer, instruction count and latched frame length.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr    <= '0;
      inst_count <= '0;
      len_q      <= '0;
    end else begin
      if (arm) begin
        wr_addr    <= '0;
        inst_count <= '0;
      end else if (state_q == WRITE) begin
        wr_addr    <= wr_addr + 1'b1;
        inst_count <= count_inc;
      end
      if (accept && state_q == LEN_LO) len_q[7:0]  <= byte_data;
      if (accept && state_q == LEN_HI) len_q[15:8] <= byte_data;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: a byte source drains a queue through the
// valid/ready handshake, a write monitor compares each wr_en against a
// scoreboard of expected (addr, data) pairs built from the frame contents.
module tb_inst_loader;
  import proctypes::*;

  localparam int AW = 10;
  localparam int IW = 64;

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } wr_exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_data;
  logic [AW:0]   inst_count;
  logic          proc_hold;
  logic          load_done;
  logic          load_error;

  logic [7:0] tx_q[$];
  wr_exp_t    exp_q[$];
  int         wr_cyc_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_acc_cyc = 0;
  int         wr_seen = 0;
  logic [7:0] last_xor;

  inst_loader #(.INST_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .clk_100mhz (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .inst_count (inst_count),
    .proc_hold  (proc_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte source: present the queue head; pop it when the upcoming edge will
  // consume it (byte_ready only changes on the clock edge).
  initial begin
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_q.size() > 0) begin
        byte_valid = 1'b1;
        byte_data  = tx_q[0];
        if (byte_ready && rst_n) begin
          void'(tx_q.pop_front());
          last_acc_cyc = cyc + 1;
        end
      end else begin
        byte_valid = 1'b0;
      end
    end
  end

  // Write monitor against the scoreboard.
  initial begin
    wr_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wr_en) begin
        wr_seen++;
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("spurious_wr_en", 64'(wr_en), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_data", wr_data, e.data);
          check("wr_latency", 64'(cyc), 64'(last_acc_cyc));
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input int n, input bit rnd, input logic [7:0] base);
    logic [7:0]  b;
    logic [63:0] w;
    logic [7:0]  x;
    logic [15:0] len;
    x   = 8'h00;
    len = 16'(n);
    tx_q.push_back(len[7:0]);
    tx_q.push_back(len[15:8]);
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int k = 0; k < INST_BYTES; k++) begin
        b = rnd ? 8'($urandom) : 8'(int'(base) + INST_BYTES * i + k);
        tx_q.push_back(b);
        x ^= b;
        w |= 64'(b) << (8 * k);
      end
      exp_q.push_back('{addr: AW'(i), data: w});
    end
`ifdef INST_LOADER_CHECKSUM_EN
    tx_q.push_back(x);
`endif
    last_xor = x;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(load_done || load_error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_writes(input int target, input int budget);
    int n = 0;
    while (wr_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_wr_timeout", 64'(wr_seen >= target), 64'd1);
  endtask

  task automatic check_done(input string tag, input int n);
    check({tag, "_load_done"},  64'(load_done),  64'd1);
    check({tag, "_load_error"}, 64'(load_error), 64'd0);
    check({tag, "_proc_hold"},  64'(proc_hold),  64'd0);
    check({tag, "_inst_count"}, 64'(inst_count), 64'(n));
    check({tag, "_wr_addr"},    64'(wr_addr),    64'(n % (1 << AW)));
    check({tag, "_missing_wr"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int w0;
    int t0;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_wr_en",      64'(wr_en),      64'd0);
    check("rst_wr_addr",    64'(wr_addr),    64'd0);
    check("rst_wr_data",    wr_data,         64'd0);
    check("rst_inst_count", 64'(inst_count), 64'd0);
    check("rst_proc_hold",  64'(proc_hold),  64'd1);
    check("rst_load_done",  64'(load_done),  64'd0);
    check("rst_load_error", 64'(load_error), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // N=2, bytes 0x01..0x10; bytes queued before start are held off.
    push_frame(2, 1'b0, 8'h01);
    check("xor_0x01_0x10", 64'(last_xor), 64'h10);
    pulse_start();
    wait_end("n2", 200);
    check_done("n2", 2);
    check("n2_byte_ready", 64'(byte_ready), 64'd0);

    // N=0 frame: no write, load_done two cycles after LEN_HI.
    w0 = wr_seen;
    push_frame(0, 1'b0, 8'h00);
    pulse_start();
    check("restart_proc_hold", 64'(proc_hold), 64'd1);
    wait_end("n0", 50);
    t0 = cyc - last_acc_cyc + 1;
`ifdef INST_LOADER_CHECKSUM_EN
    check("n0_done_latency", 64'(t0), 64'd1);
`else
    check("n0_done_latency", 64'(t0), 64'd2);
`endif
    check_done("n0", 0);
    check("n0_no_writes", 64'(wr_seen), 64'(w0));

    // N=0x0401 exceeds capacity: error after LEN_HI, no writes.
    w0 = wr_seen;
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h04);
    pulse_start();
    wait_end("ovf", 50);
    check("ovf_load_error", 64'(load_error), 64'd1);
    check("ovf_load_done",  64'(load_done),  64'd0);
    check("ovf_proc_hold",  64'(proc_hold),  64'd1);
    repeat (3) @(negedge clk);
    check("ovf_no_writes",  64'(wr_seen),    64'(w0));

`ifdef INST_LOADER_CHECKSUM_EN
    // Bad checksum: payload XOR 0x5A, 0x5B sent.
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h5A);
    for (int k = 1; k < INST_BYTES; k++) tx_q.push_back(8'h00);
    exp_q.push_back('{addr: AW'(0), data: 64'h5A});
    tx_q.push_back(8'h5B);
    pulse_start();
    wait_end("csum_bad", 100);
    check("csum_bad_error", 64'(load_error), 64'd1);
    check("csum_bad_done",  64'(load_done),  64'd0);
    push_frame(1, 1'b1, 8'h00);
    pulse_start();
    wait_end("csum_good", 100);
    check_done("csum_good", 1);
`endif

    // Continuous valid: ready drops exactly one cycle per word.
    wr_cyc_q.delete();
    push_frame(4, 1'b1, 8'h00);
    pulse_start();
    wait_end("stream", 200);
    check_done("stream", 4);
    check("stream_wr_pulses", 64'(wr_cyc_q.size()), 64'd4);
    for (int i = 1; i < wr_cyc_q.size(); i++)
      check("stream_wr_spacing", 64'(wr_cyc_q[i] - wr_cyc_q[i-1]), 64'(INST_BYTES + 1));

    // Reset mid-payload, then reload with start pulses during PAYLOAD.
    w0 = wr_seen;
    push_frame(3, 1'b1, 8'h00);
    pulse_start();
    wait_writes(w0 + 1, 100);
    #2 rst_n = 1'b0;
    #1;
    check("arst_byte_ready", 64'(byte_ready), 64'd0);
    check("arst_wr_en",      64'(wr_en),      64'd0);
    check("arst_wr_addr",    64'(wr_addr),    64'd0);
    check("arst_inst_count", 64'(inst_count), 64'd0);
    check("arst_proc_hold",  64'(proc_hold),  64'd1);
    check("arst_load_done",  64'(load_done),  64'd0);
    tx_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w0 = wr_seen;
    push_frame(2, 1'b0, 8'h40);
    pulse_start();
    wait_writes(w0 + 1, 100);
    @(negedge clk);
    pulse_start();
    pulse_start();
    wait_end("reload", 200);
    check_done("reload", 2);

    // Full capacity: 2^AW words, last write at 2^AW-1, wr_addr wraps to 0.
    push_frame(1 << AW, 1'b1, 8'h00);
    pulse_start();
    wait_end("full", 12000);
    check_done("full", 1 << AW);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
